sequenciador_controle: RTL and testbench
========================================

# sequenciador_controle

Multi-cycle fetch/decode/execute controller for the 8-bit processor. It drives every load, increment, bus-select, ALU-select and memory-write strobe of the datapath (PC, MAR, IR, A, B, CCR, ROM/RAM, output port). It steps through a fixed state machine per instruction and honours the one-cycle read latency of the synchronous data RAM. It replaces the single-cycle opcode decoder inside `processador_8bits`.

## Interface
Parameters:
- `LARGURA_ESTADO`, default 5: width of the state register and of `estado_atual`.

Ports:
- `clock` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `IR` input 8: current instruction register contents.
- `NZVC` input 4: CCR contents. [3]=N, [2]=Z, [1]=V, [0]=C.
- `bus1_sel` output 2: Bus1 source. 00=PC, 01=A, 10=B.
- `bus2_sel` output 2: Bus2 source. 00=ALU result, 01=Bus1, 10=memory data.
- `alu_sel` output 4: ALU operation code.
- `PC_inc`, `PC_load`, `MAR_load`, `IR_load`, `A_load`, `B_load`, `CCR_load`, `write` output 1 each: datapath strobes, active high.
- `halted` output 1: high in the HALT state.
- `estado_atual` output LARGURA_ESTADO: current state code, for debug and for the bench.

## Operation
- Outputs are a Moore decode of the state register plus `IR`. Outputs not listed for a state are 0.
- **Reset:**
  - While `reset`=0, the state register is forced to F0 and every output is driven to 0.
  - Reset asserted mid-instruction aborts it immediately. No partial `write` may follow.
- **Fetch sequence:**
  - F0: `bus1_sel`=00, `bus2_sel`=01, `MAR_load`.
  - F1: `PC_inc`.
  - F2: `bus2_sel`=10, `IR_load`.
  - D0: decode `IR`, no strobes. Then go to the first execute state, or to F0 for NOP.
- **Execute states:**
  - Every state named E0..E4 below belongs to the opcode being executed.
  - After the last execute state, go to F0.
- **0x00 NOP:** no execute states.
- **0x86 LDA_IMM / 0x88 LDB_IMM:**
  - E0: MAR←PC (F0 selects + `MAR_load`).
  - E1: `PC_inc`.
  - E2: `bus2_sel`=10, `A_load` (`B_load` for 0x88).
- **0x87 LDA_DIR / 0x89 LDB_DIR:**
  - E0: MAR←PC.
  - E1: `PC_inc`.
  - E2: `bus2_sel`=10, `MAR_load`.
  - E3: RAM wait.
  - E4: `bus2_sel`=10, `A_load` (`B_load` for 0x89).
- **0x96 STA_DIR:**
  - E0: MAR←PC.
  - E1: `PC_inc`.
  - E2: `bus2_sel`=10, `MAR_load`.
  - E3: `bus1_sel`=01, `write`.
- **0x42 ADD_AB / 0x43 SUB_AB / 0x44 AND_AB / 0x45 OR_AB:**
  - E0: `alu_sel`=0000 / 0001 / 0010 / 0011, `bus1_sel`=01, `bus2_sel`=00, `A_load`, `CCR_load`.
- **0x20 BRA:**
  - E0: MAR←PC.
  - E1: wait.
  - E2: `bus2_sel`=10, `PC_load`.
- **0x23 BEQ:**
  - `NZVC[2]` is sampled in D0.
  - If Z=1: follow the BRA sequence.
  - If Z=0: E0 `PC_inc` only, skipping the operand.
- **Any other opcode:** go to HALT. HALT keeps all strobes at 0 and `halted`=1 until `reset`.
- `alu_sel` stays 0000 in every state except the ALU E0 states.

## Timing
- The cycle count includes F0..D0 (4 cycles):
  - NOP: 4
  - ALU ops: 5
  - BEQ not taken: 5
  - LDx_IMM: 7
  - BRA: 7
  - BEQ taken: 7
  - STA_DIR: 8
  - LDx_DIR: 9
- Memory reads: the address is latched in MAR at edge k, and data is used on Bus2 in cycle k+2.
- `write` is high for exactly one cycle per STA_DIR. The MAR holding the target address is stable for that whole cycle.
- At most one of `PC_inc` / `PC_load` is high in any cycle.
- At most one of `A_load` / `B_load` / `IR_load` is high in any cycle.
- PC wraps 0xFF→0x00 in the datapath. The controller does not care.
- Branch decision uses `NZVC` as registered before D0. A CCR update from the preceding ALU op (E0 edge) is visible.
- First F0 strobes appear in the cycle after `reset` deasserts.

## Test plan
- **Reset mid-STA_DIR:** pull `reset` low in E2 → all outputs 0 immediately. After release: `estado_atual`=F0, `MAR_load`=1, `bus1_sel`=00, and `write` is never pulsed.
- **Program 86 AA 96 E0:**
  - F2 `IR_load` at cycle 3; `A_load` in cycle 7; `write` exactly once in cycle 15.
  - STA sequence from cycle 8 is F0,F1,F2,D0,E0,E1,E2,E3, so E3 = cycle 15 with `bus1_sel`=01.
- **IR=0x43 in D0:** next cycle shows `alu_sel`=0001, `bus1_sel`=01, `bus2_sel`=00, `A_load`=1, `CCR_load`=1. The state after that is F0.
- **BEQ with NZVC=0100:** `PC_load` in the 7th cycle of the instruction.
- **BEQ with NZVC=0000:** only `PC_inc` in the 5th cycle; `PC_load` is never asserted.
- **LDA_DIR:** `MAR_load` in E2, no strobe in E3, `A_load` with `bus2_sel`=10 in E4. The total is 9 cycles.
- **IR=0xFF:** after D0, `halted`=1 with all strobes 0 for 20 cycles. Reset recovers to F0.

Source files
------------

// File: rtl/sequenciador_controle.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit processor.
// Moore decode of the state register (plus IR) into every datapath strobe.
module sequenciador_controle #(
  parameter int LARGURA_ESTADO = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                IR,
  input  logic [3:0]                NZVC,
  output logic [1:0]                bus1_sel,
  output logic [1:0]                bus2_sel,
  output logic [3:0]                alu_sel,
  output logic                      PC_inc,
  output logic                      PC_load,
  output logic                      MAR_load,
  output logic                      IR_load,
  output logic                      A_load,
  output logic                      B_load,
  output logic                      CCR_load,
  output logic                      write,
  output logic                      halted,
  output logic [LARGURA_ESTADO-1:0] estado_atual
);

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  // F0 is code 0; execute states are private to their opcode family.
  typedef enum logic [4:0] {
    F0    = 5'd0,
    F1    = 5'd1,
    F2    = 5'd2,
    D0    = 5'd3,
    LI_E0 = 5'd4,
    LI_E1 = 5'd5,
    LI_E2 = 5'd6,
    LD_E0 = 5'd7,
    LD_E1 = 5'd8,
    LD_E2 = 5'd9,
    LD_E3 = 5'd10,
    LD_E4 = 5'd11,
    ST_E0 = 5'd12,
    ST_E1 = 5'd13,
    ST_E2 = 5'd14,
    ST_E3 = 5'd15,
    AL_E0 = 5'd16,
    BR_E0 = 5'd17,
    BR_E1 = 5'd18,
    BR_E2 = 5'd19,
    BN_E0 = 5'd20,
    HALT  = 5'd21
  } estado_t;

  estado_t     estado_r;
  estado_t     estado_prox_s;
  logic [1:0]  bus1_s;
  logic [1:0]  bus2_s;
  logic [3:0]  alu_s;
  logic        pc_inc_s;
  logic        pc_load_s;
  logic        mar_load_s;
  logic        ir_load_s;
  logic        a_load_s;
  logic        b_load_s;
  logic        ccr_load_s;
  logic        write_s;
  logic        halted_s;

  function automatic logic desvio_tomado(input logic [7:0] opcode, input logic [3:0] ccr);
    desvio_tomado = (opcode == OP_BRA) || ((opcode == OP_BEQ) && ccr[2]);
  endfunction

  function automatic logic [3:0] alu_codigo(input logic [7:0] opcode);
    case (opcode)
      OP_ADD_AB: alu_codigo = 4'b0000;
      OP_SUB_AB: alu_codigo = 4'b0001;
      OP_AND_AB: alu_codigo = 4'b0010;
      OP_OR_AB:  alu_codigo = 4'b0011;
      default:   alu_codigo = 4'b0000;
    endcase
  endfunction

  // State register; reset aborts any instruction and returns to F0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= F0;
    end else begin
      estado_r <= estado_prox_s;
    end
  end

  // Next-state sequencing; the branch condition is sampled only in D0.
  always_comb begin
    estado_prox_s = estado_r;
    case (estado_r)
      F0: estado_prox_s = F1;
      F1: estado_prox_s = F2;
      F2: estado_prox_s = D0;
      D0: begin
        case (IR)
          OP_NOP:                             estado_prox_s = F0;
          OP_LDA_IMM, OP_LDB_IMM:             estado_prox_s = LI_E0;
          OP_LDA_DIR, OP_LDB_DIR:             estado_prox_s = LD_E0;
          OP_STA_DIR:                         estado_prox_s = ST_E0;
          OP_ADD_AB, OP_SUB_AB,
          OP_AND_AB, OP_OR_AB:                estado_prox_s = AL_E0;
          OP_BRA, OP_BEQ:                     estado_prox_s = desvio_tomado(IR, NZVC) ? BR_E0 : BN_E0;
          default:                            estado_prox_s = HALT;
        endcase
      end
      LI_E0: estado_prox_s = LI_E1;
      LI_E1: estado_prox_s = LI_E2;
      LI_E2: estado_prox_s = F0;
      LD_E0: estado_prox_s = LD_E1;
      LD_E1: estado_prox_s = LD_E2;
      LD_E2: estado_prox_s = LD_E3;
      LD_E3: estado_prox_s = LD_E4;
      LD_E4: estado_prox_s = F0;
      ST_E0: estado_prox_s = ST_E1;
      ST_E1: estado_prox_s = ST_E2;
      ST_E2: estado_prox_s = ST_E3;
      ST_E3: estado_prox_s = F0;
      AL_E0: estado_prox_s = F0;
      BR_E0: estado_prox_s = BR_E1;
      BR_E1: estado_prox_s = BR_E2;
      BR_E2: estado_prox_s = F0;
      BN_E0: estado_prox_s = F0;
      HALT:  estado_prox_s = HALT;
      default: estado_prox_s = HALT;
    endcase
  end

  // Strobe decode; IR only matters in execute states, where it is stable.
  always_comb begin
    bus1_s     = 2'b00;
    bus2_s     = 2'b00;
    alu_s      = 4'b0000;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    mar_load_s = 1'b0;
    ir_load_s  = 1'b0;
    a_load_s   = 1'b0;
    b_load_s   = 1'b0;
    ccr_load_s = 1'b0;
    write_s    = 1'b0;
    halted_s   = 1'b0;
    case (estado_r)
      F0, LI_E0, LD_E0, ST_E0, BR_E0: begin
        bus1_s     = 2'b00;
        bus2_s     = 2'b01;
        mar_load_s = 1'b1;
      end
      F1, LI_E1, LD_E1, ST_E1, BN_E0: begin
        pc_inc_s = 1'b1;
      end
      F2: begin
        bus2_s    = 2'b10;
        ir_load_s = 1'b1;
      end
      LD_E2, ST_E2: begin
        bus2_s     = 2'b10;
        mar_load_s = 1'b1;
      end
      LI_E2: begin
        bus2_s = 2'b10;
        if (IR == OP_LDB_IMM) begin
          b_load_s = 1'b1;
        end else begin
          a_load_s = 1'b1;
        end
      end
      LD_E4: begin
        bus2_s = 2'b10;
        if (IR == OP_LDB_DIR) begin
          b_load_s = 1'b1;
        end else begin
          a_load_s = 1'b1;
        end
      end
      ST_E3: begin
        bus1_s  = 2'b01;
        write_s = 1'b1;
      end
      AL_E0: begin
        alu_s      = alu_codigo(IR);
        bus1_s     = 2'b01;
        bus2_s     = 2'b00;
        a_load_s   = 1'b1;
        ccr_load_s = 1'b1;
      end
      BR_E2: begin
        bus2_s    = 2'b10;
        pc_load_s = 1'b1;
      end
      HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        halted_s = 1'b0;
      end
    endcase
  end

  // Reset low forces every output to 0 immediately, without waiting for a clock.
  assign bus1_sel     = reset ? bus1_s     : 2'b00;
  assign bus2_sel     = reset ? bus2_s     : 2'b00;
  assign alu_sel      = reset ? alu_s      : 4'b0000;
  assign PC_inc       = reset ? pc_inc_s   : 1'b0;
  assign PC_load      = reset ? pc_load_s  : 1'b0;
  assign MAR_load     = reset ? mar_load_s : 1'b0;
  assign IR_load      = reset ? ir_load_s  : 1'b0;
  assign A_load       = reset ? a_load_s   : 1'b0;
  assign B_load       = reset ? b_load_s   : 1'b0;
  assign CCR_load     = reset ? ccr_load_s : 1'b0;
  assign write        = reset ? write_s    : 1'b0;
  assign halted       = reset ? halted_s   : 1'b0;
  assign estado_atual = LARGURA_ESTADO'(estado_r);

endmodule

// File: tb/tb_sequenciador_controle.sv
// Self-checking bench for sequenciador_controle: per-instruction cycle model
// driven by directed opcode sequences, plus literal timing pins.
module tb_sequenciador_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] NZVC;
  logic [1:0] bus1_sel;
  logic [1:0] bus2_sel;
  logic [3:0] alu_sel;
  logic       PC_inc, PC_load, MAR_load, IR_load, A_load, B_load, CCR_load, write, halted;
  logic [4:0] estado_atual;

  sequenciador_controle #(.LARGURA_ESTADO(5)) dut (
    .clock(clock), .reset(reset), .IR(IR), .NZVC(NZVC),
    .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .alu_sel(alu_sel),
    .PC_inc(PC_inc), .PC_load(PC_load), .MAR_load(MAR_load), .IR_load(IR_load),
    .A_load(A_load), .B_load(B_load), .CCR_load(CCR_load), .write(write),
    .halted(halted), .estado_atual(estado_atual)
  );

  always #5 clock = ~clock;

  // Strobe bit positions inside the 9-bit strobe field
  localparam logic [8:0] S_INC = 9'h100, S_PCL = 9'h080, S_MAR = 9'h040, S_IR  = 9'h020;
  localparam logic [8:0] S_A   = 9'h010, S_B   = 9'h008, S_CCR = 9'h004, S_WR  = 9'h002;
  localparam logic [8:0] S_HLT = 9'h001;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [16:0] exp_vec = 17'd0;
  logic        exp_f0 = 1'b0;
  logic [7:0]  cur_op = 8'h00;
  int          cur_c = 0;
  int          cyc_no = 0;
  int          first_ir = 0;
  int          first_a = 0;
  int          first_wr = 0;
  int          write_total = 0;
  logic [16:0] act_vec;

  assign act_vec = {bus1_sel, bus2_sel, alu_sel, PC_inc, PC_load, MAR_load, IR_load,
                    A_load, B_load, CCR_load, write, halted};

  function automatic logic [16:0] vec(input logic [1:0] b1, input logic [1:0] b2,
                                      input logic [3:0] alu, input logic [8:0] s);
    return {b1, b2, alu, s};
  endfunction

  // Instruction length in cycles including fetch/decode; unknown opcodes = 4 + 20 halted cycles
  function automatic int inst_len(input logic [7:0] op, input logic z);
    case (op)
      8'h00:                      return 4;
      8'h42, 8'h43, 8'h44, 8'h45: return 5;
      8'h86, 8'h88, 8'h20:        return 7;
      8'h23:                      return z ? 7 : 5;
      8'h96:                      return 8;
      8'h87, 8'h89:               return 9;
      default:                    return 24;
    endcase
  endfunction

  // Expected output vector in cycle c (0 = F0) of instruction op, with Z flag z at decode
  function automatic logic [16:0] model(input logic [7:0] op, input logic z, input int c);
    logic [16:0] mar_pc;
    logic [16:0] inc;
    logic [8:0]  dst;
    int          e;
    mar_pc = vec(2'b00, 2'b01, 4'h0, S_MAR);
    inc    = vec(2'b00, 2'b00, 4'h0, S_INC);
    dst    = (op == 8'h88 || op == 8'h89) ? S_B : S_A;
    e      = c - 4;
    if (c == 0) return mar_pc;
    if (c == 1) return inc;
    if (c == 2) return vec(2'b00, 2'b10, 4'h0, S_IR);
    if (c == 3) return 17'd0;
    case (op)
      8'h86, 8'h88:
        return (e == 0) ? mar_pc : (e == 1) ? inc : vec(2'b00, 2'b10, 4'h0, dst);
      8'h87, 8'h89:
        return (e == 0) ? mar_pc : (e == 1) ? inc : (e == 2) ? vec(2'b00, 2'b10, 4'h0, S_MAR) :
               (e == 3) ? 17'd0 : vec(2'b00, 2'b10, 4'h0, dst);
      8'h96:
        return (e == 0) ? mar_pc : (e == 1) ? inc : (e == 2) ? vec(2'b00, 2'b10, 4'h0, S_MAR) :
               vec(2'b01, 2'b00, 4'h0, S_WR);
      8'h42, 8'h43, 8'h44, 8'h45: begin
        logic [7:0] d;
        d = op - 8'h42;
        return vec(2'b01, 2'b00, d[3:0], S_A | S_CCR);
      end
      8'h20:
        return (e == 0) ? mar_pc : (e == 1) ? 17'd0 : vec(2'b00, 2'b10, 4'h0, S_PCL);
      8'h23:
        if (z) return (e == 0) ? mar_pc : (e == 1) ? 17'd0 : vec(2'b00, 2'b10, 4'h0, S_PCL);
        else   return inc;
      default:
        return vec(2'b00, 2'b00, 4'h0, S_HLT);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Per-cycle comparison against the model, plus first-event timestamps
  always @(negedge clock) begin
    if (write === 1'b1) write_total++;
    if (chk_en) begin
      cyc_no++;
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL outputs op=%h cyc=%0d: got %b expected %b", cur_op, cur_c, act_vec, exp_vec);
      end
      n_checks++;
      if ((estado_atual == 5'd0) !== exp_f0) begin
        n_fail++;
        $display("FAIL estado op=%h cyc=%0d: got %0d expected in_F0=%0b", cur_op, cur_c, estado_atual, exp_f0);
      end
      if (IR_load === 1'b1 && first_ir == 0) first_ir = cyc_no;
      if (A_load === 1'b1 && first_a == 0) first_a = cyc_no;
      if (write === 1'b1 && first_wr == 0) first_wr = cyc_no;
    end
  end

  // Runs cycles start..end of one instruction; stop >= 0 aborts mid-cycle stop
  task automatic run_instr(input logic [7:0] op, input logic z, input int start, input int stop);
    int last;
    last = (stop >= 0) ? stop : inst_len(op, z) - 1;
    for (int c = start; c <= last; c++) begin
      if (c >= 3) IR = op;
      NZVC    = (c == 3) ? {1'b0, z, 2'b00} : {1'b1, ~z, 2'b11};
      exp_vec = model(op, z, c);
      exp_f0  = (c == 0);
      cur_op  = op;
      cur_c   = c;
      chk_en  = 1'b1;
      if (stop >= 0 && c == last) begin
        @(negedge clock);
        #1;
        chk_en = 1'b0;
      end else begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  // Asserts reset mid-cycle, holds it across an edge, releases mid-cycle (F0 partial cycle)
  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("reset_outputs_zero", 32'(act_vec), 32'd0);
    check("reset_estado_f0", 32'(estado_atual), 32'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("release_estado_f0", 32'(estado_atual), 32'd0);
    check("release_mar_load", 32'(MAR_load), 32'd1);
    check("release_bus1_sel", 32'(bus1_sel), 32'd0);
    check("release_write", 32'(write), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    IR    = 8'h00;
    NZVC  = 4'h0;
    do_reset();
    cyc_no = 1;
    // Program 86 AA 96 E0
    run_instr(8'h86, 1'b0, 1, -1);
    run_instr(8'h96, 1'b0, 0, -1);
    check("ir_load_cycle", 32'(first_ir), 32'd3);
    check("a_load_cycle", 32'(first_a), 32'd7);
    check("write_cycle", 32'(first_wr), 32'd15);
    run_instr(8'h43, 1'b0, 0, -1);
    run_instr(8'h23, 1'b1, 0, -1);
    run_instr(8'h23, 1'b0, 0, -1);
    run_instr(8'h88, 1'b0, 0, -1);
    run_instr(8'h87, 1'b0, 0, -1);
    run_instr(8'h89, 1'b0, 0, -1);
    run_instr(8'h20, 1'b0, 0, -1);
    run_instr(8'h00, 1'b0, 0, -1);
    run_instr(8'h42, 1'b0, 0, -1);
    run_instr(8'h44, 1'b0, 0, -1);
    run_instr(8'h45, 1'b0, 0, -1);
    // STA aborted by reset in E2
    run_instr(8'h96, 1'b0, 0, 6);
    do_reset();
    run_instr(8'h87, 1'b0, 1, -1);
    // Illegal opcode halts for 20 cycles, then reset recovers
    run_instr(8'hFF, 1'b0, 0, -1);
    do_reset();
    run_instr(8'h00, 1'b0, 1, -1);
    run_instr(8'h42, 1'b0, 0, -1);
    check("write_pulses_total", 32'(write_total), 32'd1);
    // Hand-computed pins on the model itself
    check("len_lda_dir", 32'(inst_len(8'h87, 1'b0)), 32'd9);
    check("len_nop", 32'(inst_len(8'h00, 1'b0)), 32'd4);
    check("len_beq_nt", 32'(inst_len(8'h23, 1'b0)), 32'd5);
    check("len_beq_t", 32'(inst_len(8'h23, 1'b1)), 32'd7);
    check("len_sta", 32'(inst_len(8'h96, 1'b0)), 32'd8);
    check("model_sub_e0", 32'(model(8'h43, 1'b0, 4)), 32'(17'b01_00_0001_0_0001_0100));
    check("model_sta_e3", 32'(model(8'h96, 1'b0, 7)), 32'(17'b01_00_0000_0_0000_0010));
    check("model_beq_t_e2", 32'(model(8'h23, 1'b1, 6)), 32'(17'b00_10_0000_0_1000_0000));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
